// File: rtl/nfu3_pwl_act.sv
// rtl/nfu3_pwl_act.sv - pipelined piecewise-linear activation unit for the NFU-3 stage
module nfu3_pwl_act #(
    parameter int BIT_WIDTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int Tn        = 16,
    parameter int SEG_BITS  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load_start,
    input  logic [2*BIT_WIDTH-1:0]    i_coef,
    input  logic                      i_coef_valid,
    output logic                      o_coef_ready,
    output logic                      o_load_ready,
    output logic                      o_table_valid,
    input  logic [Tn*BIT_WIDTH-1:0]   i_x,
    input  logic [1:0]                i_mode,
    input  logic                      i_valid,
    output logic                      o_in_ready,
    output logic [Tn*BIT_WIDTH-1:0]   o_y,
    output logic                      o_valid,
    input  logic                      i_out_ready
);
    localparam int BW   = BIT_WIDTH;
    localparam int W2   = 2 * BIT_WIDTH;
    localparam int NSEG = 1 << SEG_BITS;

    localparam logic [SEG_BITS-1:0] SEG_FLIP = SEG_BITS'(1) << (SEG_BITS - 1);
    localparam logic [SEG_BITS-1:0] SEG_LAST = SEG_BITS'(NSEG - 1);
    localparam logic signed [W2:0]  SMAX     = {{(BW + 2){1'b0}}, {(BW - 1){1'b1}}};
    localparam logic signed [W2:0]  SMIN     = {{(BW + 2){1'b1}}, {(BW - 1){1'b0}}};
    localparam logic [BW-1:0]       YMAX     = {1'b0, {(BW - 1){1'b1}}};
    localparam logic [BW-1:0]       YMIN     = {1'b1, {(BW - 1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    state_t              state;
    logic [SEG_BITS-1:0] cnt;
    logic [W2-1:0]       coef_tbl [NSEG];

    logic v0, v1, v2;
    logic enable, accept, load_go, coef_we;

    assign enable        = !v2 || i_out_ready;
    assign o_valid       = v2;
    assign o_in_ready    = (state == READY) && enable;
    assign o_coef_ready  = (state == LOAD);
    assign o_load_ready  = (state != LOAD) && !(v0 || v1 || v2);
    assign accept        = i_valid && o_in_ready;
    // A restart request is honoured inside LOAD too; it wins over a same-cycle word.
    assign load_go       = i_load_start && (o_load_ready || state == LOAD);
    assign coef_we       = (state == LOAD) && i_coef_valid && !i_load_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            cnt           <= '0;
            o_table_valid <= 1'b0;
        end else if (load_go) begin
            state         <= LOAD;
            cnt           <= '0;
            o_table_valid <= 1'b0;
        end else if (coef_we) begin
            cnt <= cnt + SEG_BITS'(1);
            if (cnt == SEG_LAST) begin
                state         <= READY;
                o_table_valid <= 1'b1;
            end
        end
    end

    // The table survives reset; it is only meaningful once o_table_valid is set.
    always_ff @(posedge clk) begin
        if (coef_we)
            coef_tbl[cnt] <= i_coef;
    end

    logic [BW-1:0]       s0_x    [Tn];
    logic [SEG_BITS-1:0] s0_seg  [Tn];
    logic [1:0]          s0_mode;
    logic [W2-1:0]       s1_p    [Tn];
    logic [BW-1:0]       s1_b    [Tn];
    logic [BW-1:0]       s1_x    [Tn];
    logic [1:0]          s1_mode;

    logic [W2-1:0]       rd      [Tn];
    logic [W2-1:0]       prod    [Tn];
    logic signed [W2:0]  t       [Tn];
    logic [BW-1:0]       res     [Tn];

    always_comb begin
        for (int i = 0; i < Tn; i++) begin
            rd[i]   = coef_tbl[s0_seg[i]];
            prod[i] = {{BW{s0_x[i][BW-1]}}, s0_x[i]} * {{BW{rd[i][W2-1]}}, rd[i][W2-1:BW]};
        end
    end

    always_comb begin
        for (int i = 0; i < Tn; i++) begin
            t[i] = ($signed({s1_p[i][W2-1], s1_p[i]}) >>> FRAC_BITS)
                 + $signed({{(BW + 1){s1_b[i][BW-1]}}, s1_b[i]});
            res[i] = s1_x[i];
            case (s1_mode)
                2'd0: begin
                    if (t[i] > SMAX)
                        res[i] = YMAX;
                    else if (t[i] < SMIN)
                        res[i] = YMIN;
                    else
                        res[i] = t[i][BW-1:0];
                end
                2'd2:    res[i] = s1_x[i][BW-1] ? '0 : s1_x[i];
                default: res[i] = s1_x[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            o_y <= '0;
        end else if (enable) begin
            v0 <= accept;
            v1 <= v0;
            v2 <= v1;
            if (accept) begin
                s0_mode <= i_mode;
                for (int i = 0; i < Tn; i++) begin
                    s0_x[i]   <= i_x[i*BW +: BW];
                    s0_seg[i] <= i_x[i*BW+BW-1 -: SEG_BITS] ^ SEG_FLIP;
                end
            end
            if (v0) begin
                s1_mode <= s0_mode;
                for (int i = 0; i < Tn; i++) begin
                    s1_p[i] <= prod[i];
                    s1_b[i] <= rd[i][BW-1:0];
                    s1_x[i] <= s0_x[i];
                end
            end
            if (v1) begin
                for (int i = 0; i < Tn; i++)
                    o_y[i*BW +: BW] <= res[i];
            end
        end
    end
endmodule

// File: tb/tb_nfu3_pwl_act.sv
// tb/tb_nfu3_pwl_act.sv - scoreboard bench for nfu3_pwl_act
module tb_nfu3_pwl_act;
    localparam int BW = 16;
    localparam int TN = 16;
    localparam int W  = BW * TN;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_load_start;
    logic [31:0]   i_coef;
    logic          i_coef_valid;
    logic          o_coef_ready, o_load_ready, o_table_valid;
    logic [W-1:0]  i_x;
    logic [1:0]    i_mode;
    logic          i_valid, o_in_ready;
    logic [W-1:0]  o_y;
    logic          o_valid, i_out_ready;

    nfu3_pwl_act #(.BIT_WIDTH(BW), .FRAC_BITS(8), .Tn(TN), .SEG_BITS(4)) dut (
        .clk(clk), .rst(rst),
        .i_load_start(i_load_start), .i_coef(i_coef), .i_coef_valid(i_coef_valid),
        .o_coef_ready(o_coef_ready), .o_load_ready(o_load_ready), .o_table_valid(o_table_valid),
        .i_x(i_x), .i_mode(i_mode), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .o_y(o_y), .o_valid(o_valid), .i_out_ready(i_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        bit           lat;
    } exp_t;

    exp_t         exp_q[$];
    int           acc_q[$];
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] prev_y;
    bit           prev_stall = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk4(input logic [15:0] a, b, c, d);
        logic [W-1:0] v;
        for (int i = 0; i < TN; i++)
            case (i % 4)
                0: v[i*BW +: BW] = a;
                1: v[i*BW +: BW] = b;
                2: v[i*BW +: BW] = c;
                default: v[i*BW +: BW] = d;
            endcase
        return v;
    endfunction

    function automatic logic [W-1:0] mk2(input logic [15:0] a, b);
        return mk4(a, b, a, b);
    endfunction

    function automatic logic [W-1:0] bp_vec(input int k);
        logic [W-1:0] v;
        for (int i = 0; i < TN; i++)
            v[i*BW +: BW] = 16'(k * 16'h0111 + i * 16'h0203 + 16'h8001);
        return v;
    endfunction

    // kind 0: identity, 1: b=k<<8, 2: a=4.0, 3: a=0.5
    function automatic logic [31:0] coef_word(input int kind, input int k);
        case (kind)
            0:       return {16'h0100, 16'h0000};
            1:       return {16'h0000, 16'(k << 8)};
            2:       return {16'h0400, 16'h0000};
            default: return {16'h0080, 16'h0000};
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", W'(o_valid), W'(1));
                chk("stall_y", o_y, prev_y);
            end
            if (i_valid && o_in_ready)
                acc_q.push_back(cyc);
            if (o_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat act=%h", o_y);
                end else begin
                    exp_t e;
                    int   a;
                    e = exp_q.pop_front();
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
                    chk("data", o_y, e.y);
                    if (e.lat)
                        chk("latency", W'(cyc - a), W'(3));
                end
            end
            prev_stall = o_valid && !i_out_ready;
            prev_y     = o_y;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [1:0] mode,
                        input logic [W-1:0] y, input bit lat);
        exp_t e;
        bit   ok;
        int   n;
        e.y = y;
        e.lat = lat;
        exp_q.push_back(e);
        i_x = x;
        i_mode = mode;
        i_valid = 1'b1;
        ok = 0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = o_in_ready;
            tick();
            n++;
        end
        i_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout act=%0d exp=1", ok);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", W'(exp_q.size()), W'(0));
        repeat (2) tick();
    endtask

    task automatic start_load();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic write_words(input int kind, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            i_coef = coef_word(kind, k);
            i_coef_valid = 1'b1;
            tick();
        end
        i_coef_valid = 1'b0;
    endtask

    task automatic load_table(input int kind);
        start_load();
        write_words(kind, 0, 15);
        chk("table_valid", W'(o_table_valid), W'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_load_start = 1'b0;
        i_coef = '0;
        i_coef_valid = 1'b0;
        i_x = '0;
        i_mode = 2'd0;
        i_valid = 1'b0;
        i_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_o_valid", W'(o_valid), W'(0));
        chk("rst_o_y", o_y, '0);
        chk("rst_in_ready", W'(o_in_ready), W'(0));
        chk("rst_coef_ready", W'(o_coef_ready), W'(0));
        chk("rst_table_valid", W'(o_table_valid), W'(0));
        chk("rst_load_ready", W'(o_load_ready), W'(1));
        tick();

        // identity with latency measurement
        load_table(0);
        send(mk2(16'h0180, 16'hFE80), 2'd0, mk2(16'h0180, 16'hFE80), 1);
        drain();

        // restart mid-load, then segment table
        start_load();
        write_words(0, 0, 4);
        start_load();
        write_words(1, 0, 14);
        chk("restart_tv_15", W'(o_table_valid), W'(0));
        write_words(1, 15, 15);
        chk("restart_tv_16", W'(o_table_valid), W'(1));
        send(mk4(16'h8000, 16'h0000, 16'h7FFF, 16'hF000), 2'd0,
             mk4(16'h0000, 16'h0800, 16'h0F00, 16'h0700), 1);
        drain();

        // saturation and floor rounding
        load_table(2);
        send(mk2(16'h4000, 16'hC000), 2'd0, mk2(16'h7FFF, 16'h8000), 0);
        drain();
        load_table(3);
        send(mk2(16'hFFFF, 16'h0100), 2'd0, mk2(16'hFFFF, 16'h0080), 0);
        drain();

        // backpressure over a back-to-back stream
        load_table(0);
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(bp_vec(k), 2'd0, bp_vec(k), 0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 i_out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 i_out_ready = 1'b1;
            end
        join
        drain();

        // load request with beats in flight is ignored
        i_out_ready = 1'b0;
        send(mk2(16'h0011, 16'h0022), 2'd1, mk2(16'h0011, 16'h0022), 0);
        send(mk2(16'h0033, 16'hFF44), 2'd2, mk2(16'h0033, 16'h0000), 0);
        i_load_start = 1'b1;
        @(negedge clk);
        chk("inflight_load_ready", W'(o_load_ready), W'(0));
        tick();
        i_load_start = 1'b0;
        @(negedge clk);
        chk("inflight_coef_ready", W'(o_coef_ready), W'(0));
        chk("inflight_table_valid", W'(o_table_valid), W'(1));
        tick();
        i_out_ready = 1'b1;
        drain();

        // reset during a load
        start_load();
        write_words(0, 0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_table_valid", W'(o_table_valid), W'(0));
        chk("abort_coef_ready", W'(o_coef_ready), W'(0));
        chk("abort_load_ready", W'(o_load_ready), W'(1));
        tick();
        i_x = mk2(16'h1234, 16'h5678);
        i_mode = 2'd1;
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_in_ready", W'(o_in_ready), W'(0));
            tick();
        end
        i_valid = 1'b0;
        repeat (6) tick();

        // non-PWL modes
        load_table(1);
        send(mk2(16'hFF00, 16'h0123), 2'd2, mk2(16'h0000, 16'h0123), 0);
        send(mk2(16'hFF00, 16'h0123), 2'd1, mk2(16'hFF00, 16'h0123), 0);
        send(mk2(16'hFF00, 16'h0123), 2'd3, mk2(16'hFF00, 16'h0123), 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
